pool_sched: RTL and testbench

- Max-pool sequencer for the pooling layers POOL1, POOL2 and POOL3.
- Walks every pooled output pixel of the current layer and reads the 2x2 window from the pool feature buffer: two reads of two samples each, upper row then lower row.
- Reduces the four samples to their signed maximum and writes the result into the conv feature buffer at the pooled coordinate.
- Launched by the top-level layer FSM; reports busy and done back to it.

---
 rtl/pool_sched_if.sv | 34 +++
 rtl/pool_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_pool_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pool_sched_if.sv
// Handshake and buffer-access bundle between the pool sequencer, the layer FSM
// and the pool/conv feature buffers.
interface pool_sched_if #(
  parameter int DATSIZE = 22,
  parameter int CW      = 6
);
  logic [3:0]           state;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [5:0]           rd_y;
  logic [5:0]           rd_x;
  logic [CW-1:0]        rd_c;
  logic                 rd_updown;
  logic [2*DATSIZE-1:0] rd_data;
  logic                 wr_en;
  logic [4:0]           wr_y;
  logic [4:0]           wr_x;
  logic [CW-1:0]        wr_c;
  logic [DATSIZE-1:0]   wr_data;

  modport master (
    input  state, start, rd_data,
    output busy, done, rd_en, rd_y, rd_x, rd_c, rd_updown,
           wr_en, wr_y, wr_x, wr_c, wr_data
  );

  modport slave (
    output state, start, rd_data,
    input  busy, done, rd_en, rd_y, rd_x, rd_c, rd_updown,
           wr_en, wr_y, wr_x, wr_c, wr_data
  );
endinterface

// File: rtl/pool_sched.sv
// 2x2 signed max-pool sequencer for POOL1/2/3: two row reads per pixel, one write per pixel.
// Optional macro POOL_SCHED_RELU_EN clamps negative maxima to zero before the write.
module pool_sched #(
  parameter int DATSIZE = 22,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  pool_sched_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_UP = 3'd1,
    ISSUE_DN = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [3:0]    POOL1 = 4'b0011;
  localparam logic [3:0]    POOL2 = 4'b0101;
  localparam logic [3:0]    POOL3 = 4'b0111;
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic signed [DATSIZE-1:0] smax(
    input logic signed [DATSIZE-1:0] a,
    input logic signed [DATSIZE-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_e                     state_q, state_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       rd_en_q, rd_en_d, rd_updown_q, rd_updown_d;
  logic [5:0]                 rd_y_q, rd_y_d, rd_x_q, rd_x_d, last_xy_q, last_xy_d;
  logic [CW-1:0]              rd_c_q, rd_c_d, last_c_q, last_c_d;
  logic                       p1_v_q, p1_v_d, p2_v_q, p2_v_d;
  logic [4:0]                 p1_y_q, p1_y_d, p1_x_q, p1_x_d, p2_y_q, p2_y_d, p2_x_q, p2_x_d;
  logic [CW-1:0]              p1_c_q, p1_c_d, p2_c_q, p2_c_d;
  logic signed [DATSIZE-1:0]  m_up_q, m_up_d;
  logic                       wr_en_q, wr_en_d;
  logic [4:0]                 wr_y_q, wr_y_d, wr_x_q, wr_x_d;
  logic [CW-1:0]              wr_c_q, wr_c_d;
  logic signed [DATSIZE-1:0]  wr_data_q, wr_data_d;
  logic signed [DATSIZE-1:0]  s0_s, s1_s, m_s;
  logic                       last_pix_s;

  assign s0_s       = bus.rd_data[DATSIZE-1:0];
  assign s1_s       = bus.rd_data[2*DATSIZE-1:DATSIZE];
  assign m_s        = smax(m_up_q, smax(s0_s, s1_s));
  assign last_pix_s = (rd_x_q == last_xy_q) && (rd_y_q == last_xy_q) && (rd_c_q == last_c_q);

  // Next-state: sequencing FSM, pixel counters and the three-stage read/max/write pipeline.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_updown_d = 1'b0;
    rd_y_d      = rd_y_q;
    rd_x_d      = rd_x_q;
    rd_c_d      = rd_c_q;
    last_xy_d   = last_xy_q;
    last_c_d    = last_c_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.state)
            POOL1: begin last_xy_d = 6'd15; last_c_d = CW'(6'd15); end
            POOL2: begin last_xy_d = 6'd7;  last_c_d = CW'(6'd31); end
            POOL3: begin last_xy_d = 6'd3;  last_c_d = CW'(6'd63); end
            default: begin last_xy_d = last_xy_q; last_c_d = last_c_q; end
          endcase
          if (bus.state == POOL1 || bus.state == POOL2 || bus.state == POOL3) begin
            state_d = ISSUE_UP;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
            rd_y_d  = 6'd0;
            rd_x_d  = 6'd0;
            rd_c_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE_UP: begin
        state_d     = ISSUE_DN;
        rd_en_d     = 1'b1;
        rd_updown_d = 1'b1;
      end
      ISSUE_DN: begin
        if (rd_x_q == last_xy_q) begin
          rd_x_d = 6'd0;
          if (rd_y_q == last_xy_q) begin
            rd_y_d = 6'd0;
            rd_c_d = (rd_c_q == last_c_q) ? '0 : rd_c_q + C_ONE;
          end else begin
            rd_y_d = rd_y_q + 6'd1;
          end
        end else begin
          rd_x_d = rd_x_q + 6'd1;
        end
        if (last_pix_s) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE_UP;
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        // The final write is on the bus this cycle once wr_en_q rises.
        if (wr_en_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: begin state_d = IDLE; busy_d = 1'b0; end
    endcase

    p1_v_d = rd_en_q && !rd_updown_q;
    p1_y_d = rd_y_q[4:0];
    p1_x_d = rd_x_q[4:0];
    p1_c_d = rd_c_q;
    p2_v_d = p1_v_q;
    p2_y_d = p1_y_q;
    p2_x_d = p1_x_q;
    p2_c_d = p1_c_q;
    m_up_d = p1_v_q ? smax(s0_s, s1_s) : m_up_q;

    wr_en_d = p2_v_q;
    if (p2_v_q) begin
      wr_y_d = p2_y_q;
      wr_x_d = p2_x_q;
      wr_c_d = p2_c_q;
`ifdef POOL_SCHED_RELU_EN
      wr_data_d = m_s[DATSIZE-1] ? '0 : m_s;
`else
      wr_data_d = m_s;
`endif
    end else begin
      wr_y_d    = wr_y_q;
      wr_x_d    = wr_x_q;
      wr_c_d    = wr_c_q;
      wr_data_d = wr_data_q;
    end
  end

  // State and output registers; reset aborts any layer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_updown_q <= 1'b0;
      rd_y_q      <= 6'd0;
      rd_x_q      <= 6'd0;
      rd_c_q      <= '0;
      last_xy_q   <= 6'd0;
      last_c_q    <= '0;
      p1_v_q      <= 1'b0;
      p1_y_q      <= 5'd0;
      p1_x_q      <= 5'd0;
      p1_c_q      <= '0;
      p2_v_q      <= 1'b0;
      p2_y_q      <= 5'd0;
      p2_x_q      <= 5'd0;
      p2_c_q      <= '0;
      m_up_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_y_q      <= 5'd0;
      wr_x_q      <= 5'd0;
      wr_c_q      <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_updown_q <= rd_updown_d;
      rd_y_q      <= rd_y_d;
      rd_x_q      <= rd_x_d;
      rd_c_q      <= rd_c_d;
      last_xy_q   <= last_xy_d;
      last_c_q    <= last_c_d;
      p1_v_q      <= p1_v_d;
      p1_y_q      <= p1_y_d;
      p1_x_q      <= p1_x_d;
      p1_c_q      <= p1_c_d;
      p2_v_q      <= p2_v_d;
      p2_y_q      <= p2_y_d;
      p2_x_q      <= p2_x_d;
      p2_c_q      <= p2_c_d;
      m_up_q      <= m_up_d;
      wr_en_q     <= wr_en_d;
      wr_y_q      <= wr_y_d;
      wr_x_q      <= wr_x_d;
      wr_c_q      <= wr_c_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_updown = rd_updown_q;
  assign bus.rd_y      = rd_y_q;
  assign bus.rd_x      = rd_x_q;
  assign bus.rd_c      = rd_c_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_c      = wr_c_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_pool_sched.sv
// Scoreboard bench for pool_sched: a pool-buffer model answers reads, expected
// writes are queued at each launch and popped as the sequencer writes.
module tb_pool_sched;
  localparam int DATSIZE = 22;
  localparam int CW      = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_sched_if #(.DATSIZE(DATSIZE), .CW(CW)) bus();
  pool_sched #(.DATSIZE(DATSIZE), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0]        coord;
    logic [DATSIZE-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   first_wr_cyc = -1;
  int   first_rd_cyc = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel (c,y,x) = (0,0,0), (1,0,0) and (0,0,1) carry the directed corner patterns.
  function automatic logic signed [DATSIZE-1:0] sample(input int c, input int y, input int x,
                                                       input int ud, input int half);
    logic [31:0] h;
    if (c == 0 && y == 0 && x == 0)
      return (ud == 0) ? ((half == 0) ? 22'sd5 : -22'sd3) : ((half == 0) ? 22'sd7 : 22'sd2);
    if (c == 1 && y == 0 && x == 0)
      return (ud == 0) ? ((half == 0) ? -22'sd9 : -22'sd4) : ((half == 0) ? -22'sd12 : -22'sd4);
    if (c == 0 && y == 0 && x == 1)
      return (ud == 0) ? ((half == 0) ? 22'h200000 : 22'h1FFFFF) : 22'h200000;
    h = (32'(c) * 32'd7919 + 32'(y) * 32'd613 + 32'(x) * 32'd97 + 32'(ud) * 32'd31
         + 32'(half) * 32'd13 + 32'd1) * 32'd2654435761;
    return h[27:6];
  endfunction

  function automatic logic [DATSIZE-1:0] model_pix(input int c, input int y, input int x);
    logic signed [DATSIZE-1:0] m;
    logic signed [DATSIZE-1:0] v;
    m = sample(c, y, x, 0, 0);
    for (int k = 1; k < 4; k++) begin
      v = sample(c, y, x, k / 2, k % 2);
      if (v > m) m = v;
    end
`ifdef POOL_SCHED_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  // Pool buffer model: one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (bus.rd_en)
      bus.rd_data <= {sample(int'(bus.rd_c), int'(bus.rd_y), int'(bus.rd_x), int'(bus.rd_updown), 1),
                      sample(int'(bus.rd_c), int'(bus.rd_y), int'(bus.rd_x), int'(bus.rd_updown), 0)};
  end

  // Write monitor: every conv-buffer write is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (bus.wr_en) begin
        if (wr_count == 0) first_wr_cyc = cyc;
        wr_count++;
        if (sb_q.size() == 0) begin
          check_eq("wr_unexpected", 64'(bus.wr_en), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("wr_coord", 64'({bus.wr_c, bus.wr_y, bus.wr_x}), 64'(e.coord));
          check_eq("wr_data", 64'(bus.wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic push_layer(input int outd, input int ch);
    exp_t e;
    for (int c = 0; c < ch; c++)
      for (int y = 0; y < outd; y++)
        for (int x = 0; x < outd; x++) begin
          e.coord = {6'(c), 5'(y), 5'(x)};
          e.data  = model_pix(c, y, x);
          sb_q.push_back(e);
        end
  endtask

  task automatic run_layer(input logic [3:0] code, input int outd, input int ch, input bit restart_mid);
    int n;
    int s;
    int done_cyc;
    n = outd * outd * ch;
    push_layer(outd, ch);
    wr_count = 0;
    first_wr_cyc = -1;
    first_rd_cyc = -1;
    done_cyc = -1;
    @(negedge clk);
    bus.state = code;
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.state = 4'b0000;
    check_eq("busy_after_start", 64'(bus.busy), 64'd1);
    for (int k = 0; k < 2 * n + 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cyc = cyc;
        check_eq("busy_at_done", 64'(bus.busy), 64'd0);
        break;
      end
      if (restart_mid) begin
        bus.start = (k == 50);
        bus.state = 4'b0111;
      end
    end
    bus.start = 1'b0;
    check_eq("done_latency", 64'(done_cyc - s), 64'(2 * n + 3));
    check_eq("first_rd_latency", 64'(first_rd_cyc - s), 64'd1);
    check_eq("first_wr_latency", 64'(first_wr_cyc - s), 64'd4);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(bus.done), 64'd0);
    repeat (6) @(negedge clk);
    check_eq("write_count", 64'(wr_count), 64'(n));
    check_eq("sb_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic activity;
    bus.state = 4'b0000;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             64'({bus.busy, bus.done, bus.rd_en, bus.rd_updown, bus.wr_en, bus.rd_y, bus.rd_x, bus.rd_c}), 64'd0);
    check_eq("reset_wr_bus", 64'({bus.wr_y, bus.wr_x, bus.wr_c, bus.wr_data}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_layer(4'b0111, 4, 64, 1'b0);

    bus.state = 4'b0010;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    activity = 1'b0;
    repeat (10) begin
      @(negedge clk);
      activity = activity | bus.busy | bus.rd_en | bus.done | bus.wr_en;
    end
    check_eq("nonpool_start_ignored", 64'(activity), 64'd0);

    run_layer(4'b0011, 16, 16, 1'b0);
    run_layer(4'b0101, 8, 32, 1'b1);

    push_layer(8, 32);
    @(negedge clk);
    bus.state = 4'b0101;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("busy_before_rst", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async_clear", 64'({bus.rd_en, bus.wr_en, bus.busy, bus.done}), 64'd0);
    @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;
    activity = 1'b0;
    repeat (5) begin
      @(negedge clk);
      activity = activity | bus.busy | bus.rd_en | bus.done | bus.wr_en;
    end
    check_eq("rst_abort_quiet", 64'(activity), 64'd0);

    run_layer(4'b0111, 4, 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
